// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, requester ids
// and the timeout counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Bits needed to count up to TIMEOUT; never less than one bit.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles without mem_ack. 'expired' is raised combinationally in
// the cycle whose increment would reach TIMEOUT, so ACCESS lasts exactly
// TIMEOUT cycles when the memory never answers. TIMEOUT=0 never expires.
module mem_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] timer;

    // Wait-cycle counter: cleared outside ACCESS, advances on unacked cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && en && (timer == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between the core (port C) and the
// debug/DMA loader (port D), runs the req/ack handshake and the wait timeout.
//
// Handshake: a requester raises *_req with a stable payload and holds it until
// its *_done pulse (one cycle, *_err valid alongside); the payload is latched
// at grant. Toward memory, mem_req stays high with a stable payload until
// mem_ack; mem_ack outside ACCESS is ignored and read data is taken with ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 15,
    parameter int CORE_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_done,
    output logic                  c_err,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    arb_state_t state, state_nxt;
    logic       pick;
    logic       winner;
    logic       last_winner;
    logic       grant;
    logic       finish;
    logic       expired;
    logic       tmr_en;
    logic       tmr_clr;

    assign tmr_en    = (state == ACCESS) && !mem_ack;
    assign tmr_clr   = (state != ACCESS);
    assign grant     = (state == IDLE) && (state_nxt == ACCESS);
    assign finish    = (state == ACCESS) && (state_nxt == RESP);
    assign state_dbg = state;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .expired (expired)
    );

    // Next-state and winner selection; ack takes precedence over timeout.
    always_comb begin
        state_nxt = state;
        pick      = PORT_C;
        case (state)
            IDLE: begin
                if (c_req || d_req) begin
                    state_nxt = ACCESS;
                    if (c_req && d_req) begin
                        pick = (CORE_PRIORITY != 0) ? PORT_C : ~last_winner;
                    end else begin
                        pick = c_req ? PORT_C : PORT_D;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack || expired) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs: payload latched at grant, completion at finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner      <= PORT_C;
            last_winner <= PORT_D;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            c_done      <= 1'b0;
            c_err       <= 1'b0;
            c_rdata     <= '0;
            d_done      <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
        end else begin
            mem_req <= (state_nxt == ACCESS);
            busy    <= (state_nxt != IDLE);
            c_done  <= 1'b0;
            c_err   <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            if (grant) begin
                winner      <= pick;
                last_winner <= pick;
                mem_we      <= (pick == PORT_D) ? d_we    : c_we;
                mem_addr    <= (pick == PORT_D) ? d_addr  : c_addr;
                mem_wdata   <= (pick == PORT_D) ? d_wdata : c_wdata;
            end
            if (finish) begin
                if (winner == PORT_C) begin
                    c_done <= 1'b1;
                    c_err  <= !mem_ack;
                    if (mem_ack && !mem_we) begin
                        c_rdata <= mem_rdata;
                    end
                end else begin
                    d_done <= 1'b1;
                    d_err  <= !mem_ack;
                    if (mem_ack && !mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with core priority, one
// with round-robin ties. Inputs change and outputs are sampled on negedges.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          c_done, c_err, d_done, d_err, mem_req, mem_we, busy;
    logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    state_dbg;

    logic          rr_c_req, rr_d_req, rr_mem_ack;
    logic          rr_c_done, rr_c_err, rr_d_done, rr_d_err, rr_mem_req, rr_mem_we, rr_busy;
    logic [DW-1:0] rr_c_rdata, rr_d_rdata, rr_mem_wdata;
    logic [AW-1:0] rr_mem_addr;
    logic [1:0]    rr_state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15), .CORE_PRIORITY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .state_dbg(state_dbg)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15), .CORE_PRIORITY(0)
    ) dut_rr (
        .clk(clk), .rst(rst),
        .c_req(rr_c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_done(rr_c_done), .c_err(rr_c_err), .c_rdata(rr_c_rdata),
        .d_req(rr_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(rr_d_done), .d_err(rr_d_err), .d_rdata(rr_d_rdata),
        .mem_req(rr_mem_req), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_ack(rr_mem_ack), .mem_rdata(mem_rdata),
        .busy(rr_busy), .state_dbg(rr_state_dbg)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        rr_c_req = 0; rr_d_req = 0; rr_mem_ack = 0;
        tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mem: got req=%0b we=%0b addr=%h wdata=%h busy=%0b want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, busy);
        end
        n_cmp++;
        if ({c_done, c_err, c_rdata, d_done, d_err, d_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_ports: got c_done=%0b c_err=%0b c_rdata=%h d_done=%0b d_err=%0b d_rdata=%h want all 0",
                     c_done, c_err, c_rdata, d_done, d_err, d_rdata);
        end
        n_cmp++;
        if (state_dbg !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 00", state_dbg);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        tick();
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, busy, c_done} !== {1'b1, 1'b0, 32'h10, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL read_access: got req=%0b we=%0b addr=%h busy=%0b done=%0b want 1 0 00000010 1 0",
                     mem_req, mem_we, mem_addr, busy, c_done);
        end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if ({c_done, c_err, c_rdata, mem_req, d_done} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL read_done: got done=%0b err=%0b rdata=%h mem_req=%0b d_done=%0b want 1 0 deadbeef 0 0",
                     c_done, c_err, c_rdata, mem_req, d_done);
        end
        mem_ack = 0; c_req = 0;
        tick();
        n_cmp++;
        if ({c_done, mem_req, busy, state_dbg} !== {1'b0, 1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL read_idle: got done=%0b req=%0b busy=%0b state=%b want 0 0 0 00",
                     c_done, mem_req, busy, state_dbg);
        end
    endtask

    task automatic test_priority_tie();
        c_req = 1; c_we = 0; c_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
            n_bad++;
            $display("FAIL tie_grant_c: got req=%0b addr=%h want 1 00000100", mem_req, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        n_cmp++;
        if ({c_done, d_done, c_rdata} !== {1'b1, 1'b0, 32'h11111111}) begin
            n_bad++;
            $display("FAIL tie_c_done: got c_done=%0b d_done=%0b c_rdata=%h want 1 0 11111111",
                     c_done, d_done, c_rdata);
        end
        mem_ack = 0; c_req = 0;
        tick();
        n_cmp++;
        if ({mem_req, state_dbg} !== {1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL tie_gap: got req=%0b state=%b want 0 00", mem_req, state_dbg);
        end
        tick();
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
            n_bad++;
            $display("FAIL tie_grant_d: got req=%0b addr=%h want 1 00000200", mem_req, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'h22222222;
        tick();
        n_cmp++;
        if ({d_done, c_done, d_rdata, c_rdata} !== {1'b1, 1'b0, 32'h22222222, 32'h11111111}) begin
            n_bad++;
            $display("FAIL tie_d_done: got d_done=%0b c_done=%0b d_rdata=%h c_rdata=%h want 1 0 22222222 11111111",
                     d_done, c_done, d_rdata, c_rdata);
        end
        mem_ack = 0; d_req = 0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 0;
        tick();
        n_cmp++;
        if ({c_done, d_done, mem_req, state_dbg, c_rdata} !== {1'b0, 1'b0, 1'b0, 2'b00, 32'h11111111}) begin
            n_bad++;
            $display("FAIL stray_ack: got c_done=%0b d_done=%0b req=%0b state=%b c_rdata=%h want 0 0 0 00 11111111",
                     c_done, d_done, mem_req, state_dbg, c_rdata);
        end
    endtask

    task automatic test_delayed_write();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h55AA;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, d_done} !== {1'b1, 1'b1, 32'h40, 32'h55AA, 1'b0}) begin
                n_bad++;
                $display("FAIL write_hold[%0d]: got req=%0b we=%0b addr=%h wdata=%h done=%0b want 1 1 00000040 000055aa 0",
                         i, mem_req, mem_we, mem_addr, mem_wdata, d_done);
            end
            if (i == 0) begin
                d_addr = 32'h44; d_wdata = 32'hFFFF;
            end
            mem_ack = (i == 5); mem_rdata = 32'hBAD0BAD0;
        end
        tick();
        n_cmp++;
        if ({d_done, d_err, d_rdata, mem_req, c_done} !== {1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL write_done: got done=%0b err=%0b rdata=%h req=%0b c_done=%0b want 1 0 22222222 0 0",
                     d_done, d_err, d_rdata, mem_req, c_done);
        end
        mem_ack = 0; d_req = 0; d_we = 0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        bit ended;
        cnt = 0; ended = 0;
        c_req = 1; c_we = 0; c_addr = 32'h80;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req) begin
                cnt++;
            end else begin
                ended = 1;
                break;
            end
        end
        n_cmp++;
        if (!ended || cnt != 15) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d req cycles (ended=%0b) want 15", cnt, ended);
        end
        n_cmp++;
        if ({c_done, c_err, c_rdata, d_done} !== {1'b1, 1'b1, 32'h11111111, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_done: got done=%0b err=%0b rdata=%h d_done=%0b want 1 1 11111111 0",
                     c_done, c_err, c_rdata, d_done);
        end
        c_req = 0;
        tick();
        n_cmp++;
        if ({c_done, c_err, state_dbg} !== {1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL timeout_idle: got done=%0b err=%0b state=%b want 0 0 00", c_done, c_err, state_dbg);
        end
        c_req = 1; c_addr = 32'h84;
        tick();
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        n_cmp++;
        if ({c_done, c_err, c_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
            n_bad++;
            $display("FAIL timeout_recover: got done=%0b err=%0b rdata=%h want 1 0 12345678",
                     c_done, c_err, c_rdata);
        end
        mem_ack = 0; c_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        c_req = 1; c_we = 0; c_addr = 32'h90;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_pre: got req=%0b want 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req, busy, state_dbg} !== {1'b0, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL rst_mid_async: got req=%0b busy=%0b state=%b want 0 0 00", mem_req, busy, state_dbg);
        end
        tick();
        n_cmp++;
        if ({c_done, c_rdata} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL rst_mid_nodone: got done=%0b rdata=%h want 0 00000000", c_done, c_rdata);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({mem_req, mem_addr, c_done} !== {1'b1, 32'h90, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_regrant: got req=%0b addr=%h done=%0b want 1 00000090 0",
                     mem_req, mem_addr, c_done);
        end
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        n_cmp++;
        if ({c_done, c_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL rst_mid_done: got done=%0b rdata=%h want 1 cafef00d", c_done, c_rdata);
        end
        mem_ack = 0; c_req = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] got [4];
        logic [AW-1:0] want [4];
        int ngrant, nc, nd;
        ngrant = 0; nc = 0; nd = 0;
        want[0] = 32'hC0; want[1] = 32'hD0; want[2] = 32'hC0; want[3] = 32'hD0;
        c_we = 0; d_we = 0; c_addr = 32'hC0; d_addr = 32'hD0; mem_rdata = 32'h5A5A5A5A;
        rr_c_req = 1; rr_d_req = 1;
        for (int i = 0; i < 40 && ngrant < 4; i++) begin
            tick();
            if (rr_c_done) nc++;
            if (rr_d_done) nd++;
            rr_mem_ack = 0;
            if (rr_mem_req) begin
                got[ngrant] = rr_mem_addr;
                ngrant++;
                rr_mem_ack = 1;
            end
        end
        tick();
        if (rr_c_done) nc++;
        if (rr_d_done) nd++;
        rr_mem_ack = 0; rr_c_req = 0; rr_d_req = 0;
        n_cmp++;
        if (ngrant != 4) begin
            n_bad++;
            $display("FAIL rr_grants: got %0d grants want 4", ngrant);
        end
        for (int i = 0; i < ngrant; i++) begin
            n_cmp++;
            if (got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got addr %h want %h", i, got[i], want[i]);
            end
        end
        n_cmp++;
        if (nc != 2 || nd != 2) begin
            n_bad++;
            $display("FAIL rr_done_count: got c=%0d d=%0d want 2 2", nc, nd);
        end
        tick();
        n_cmp++;
        if ({rr_mem_req, rr_state_dbg, rr_busy} !== {1'b0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL rr_idle: got req=%0b state=%b busy=%0b want 0 00 0", rr_mem_req, rr_state_dbg, rr_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority_tie();
        test_stray_ack();
        test_delayed_write();
        test_timeout();
        test_reset_mid_access();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
